// File: rtl/abus_arbiter.sv
// abus_arbiter: round-robin arbiter and handshake sequencer for the shared address bus; optional ACCESS timeout via ABUS_TIMEOUT_EN
module abus_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr_in,
  input  logic                 mem_ready,
  output logic [NREQ-1:0]      grant,
  output logic [AW-1:0]        abus_out,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy
);
  localparam int LW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ABORT} state_t;
  state_t r_state, w_next;
  logic [NREQ-1:0] r_grant, w_pick;
  logic [LW-1:0] r_win, r_last, w_pick_idx, w_idx;
  logic w_any, w_to;
`ifdef ABUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  // ACCESS cycle counter; zero outside ACCESS so it is clear on every entry
  always_ff @(posedge clk)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (r_state == ACCESS) ? r_cnt + 1'b1 : '0;
  assign w_to = (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_to = 1'b0;
`endif
  // round-robin pick: scan last+1, last+2, ... so the lowest offset wins
  always_comb begin
    w_pick_idx = r_last;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = LW'((int'(r_last) + k) % NREQ);
      if (req[w_idx]) begin
        w_pick_idx = w_idx;
        w_any = 1'b1;
      end
    end
    w_pick = NREQ'(1) << w_pick_idx;
  end
  // state register
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // next-state logic; mem_ready beats the timeout in the same cycle
  always_comb begin
    w_next = (r_state == IDLE)   ? (w_any ? ACCESS : IDLE) :
             (r_state == ACCESS) ? (mem_ready ? DONE : (w_to ? ABORT : ACCESS)) :
             IDLE;
  end
  // grant/winner capture and round-robin pointer; grant held until IDLE entry
  always_ff @(posedge clk)
    if (!reset) begin
      r_grant <= '0;
      r_win   <= '0;
      r_last  <= LW'(NREQ - 1);
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick;
        r_win   <= w_pick_idx;
      end else if (w_next == IDLE) r_grant <= '0;
      if (r_state == DONE || r_state == ABORT) r_last <= r_win;
    end
  // outputs: address/we mux on the registered grant, strobes from state
  always_comb begin
    abus_out = '0;
    for (int i = 0; i < NREQ; i++) abus_out = abus_out | (addr_in[i*AW +: AW] & {AW{r_grant[i]}});
    grant   = r_grant;
    mem_req = (r_state == ACCESS);
    mem_we  = mem_req & |(we & r_grant);
    done    = (r_state == DONE) ? r_grant : '0;
    busy    = (r_state != IDLE);
`ifdef ABUS_TIMEOUT_EN
    err     = (r_state == ABORT) ? r_grant : '0;
`else
    err     = '0;
`endif
  end
endmodule

// File: tb/tb_abus_arbiter.sv
// tb_abus_arbiter: directed vectors, corner sequences and randomized model check for abus_arbiter
module tb_abus_arbiter;
  localparam int N = 4, AW = 16, TO = 15;
  logic clk = 1'b0, reset = 1'b0, mem_ready = 1'b0;
  logic [N-1:0] req = '0, we = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N-1:0] grant, done, err;
  logic [AW-1:0] abus_out;
  logic mem_req, mem_we, busy;
  int checks = 0, failures = 0;
  int m_win = -1, m_ph = 0, m_last = N - 1, m_cnt = 0;

  always #5 clk = ~clk;

  abus_arbiter #(.NREQ(N), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr_in(addr_in),
    .mem_ready(mem_ready), .grant(grant), .abus_out(abus_out), .mem_req(mem_req),
    .mem_we(mem_we), .done(done), .err(err), .busy(busy)
  );

  typedef struct {
    logic rst; logic [3:0] rq; logic mr;
    logic [3:0] g; logic mq; logic [3:0] d; logic b;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // transaction-level reference: who owns the bus and which phase it is in
  task automatic madv();
    int pick;
    if (!reset) begin
      m_win = -1; m_last = N - 1; m_cnt = 0;
    end else if (m_win < 0) begin
      pick = -1;
      for (int k = 1; k <= N && pick < 0; k++)
        if (((req >> ((m_last + k) % N)) & 4'd1) != 0) pick = (m_last + k) % N;
      m_win = pick; m_ph = 0; m_cnt = 0;
    end else if (m_ph == 0) begin
      if (mem_ready) m_ph = 1;
      else begin
        m_cnt++;
`ifdef ABUS_TIMEOUT_EN
        if (m_cnt == TO) m_ph = 2;
`endif
      end
    end else begin
      m_last = m_win; m_win = -1;
    end
  endtask

  function automatic logic [30:0] mexp();
    logic [3:0] g;
    logic [AW-1:0] ab;
    logic mq, mw;
    int w;
    w  = (m_win < 0) ? 0 : m_win;
    g  = (m_win < 0) ? 4'h0 : 4'(1 << w);
    mq = (m_win >= 0) && (m_ph == 0);
    ab = (m_win < 0) ? '0 : AW'(addr_in >> (w * AW));
    mw = mq && (((we >> w) & 4'd1) != 0);
    return {g, ab, mq, mw, (m_ph == 1) ? g : 4'h0, (m_ph == 2) ? g : 4'h0, m_win >= 0};
  endfunction

  initial begin
    int nmq, ndn, nerr, stable, acc;
    vt = '{
      '{1'b0, 4'hf, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0},
      '{1'b0, 4'hf, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0},
      '{1'b1, 4'hf, 1'b1, 4'h1, 1'b1, 4'h0, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h1, 1'b0, 4'h1, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0},
      '{1'b1, 4'hf, 1'b1, 4'h2, 1'b1, 4'h0, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h2, 1'b0, 4'h2, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0},
      '{1'b1, 4'hf, 1'b1, 4'h4, 1'b1, 4'h0, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h4, 1'b0, 4'h4, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0},
      '{1'b1, 4'hf, 1'b1, 4'h8, 1'b1, 4'h0, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h8, 1'b0, 4'h8, 1'b1},
      '{1'b1, 4'hf, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0},
      '{1'b1, 4'hf, 1'b1, 4'h1, 1'b1, 4'h0, 1'b1}
    };
    for (int i = 0; i < 15; i++) begin
      reset = vt[i].rst; req = vt[i].rq; mem_ready = vt[i].mr;
      step();
      chk($sformatf("vec%0d", i), {grant, mem_req, done, busy, err},
          {vt[i].g, vt[i].mq, vt[i].d, vt[i].b, 4'h0});
    end
    // single request with memory always ready
    req = '0; do_reset();
    req = 4'b0100; we = 4'b0100; addr_in = '0; addr_in[2*AW +: AW] = 16'h1234; mem_ready = 1'b1;
    step();
    chk("single_grant", {grant, abus_out, mem_we, mem_req}, {4'b0100, 16'h1234, 1'b1, 1'b1});
    step();
    chk("single_done", {done, mem_req, grant}, {4'b0100, 1'b0, 4'b0100});
    step();
    chk("single_idle", {busy, grant, abus_out, mem_we}, {1'b0, 4'h0, 16'h0, 1'b0});
    // one-cycle request pulse with a slow memory
    req = '0; we = '0; do_reset();
    addr_in = '0; addr_in[0 +: AW] = 16'hbeef;
    req = 4'b0001; mem_ready = 1'b0;
    step();
    req = '0;
    nmq = 0; ndn = 0; stable = 1;
    for (int c = 0; c < 12; c++) begin
      if (mem_req) begin
        nmq++;
        if (abus_out != 16'hbeef) stable = 0;
      end
      if (done == 4'b0001) ndn++;
      else if (done != 0) ndn += 100;
      mem_ready = (c >= 5);
      step();
    end
    chk("slow_mem_req_cycles", nmq, 6);
    chk("slow_done_pulses", ndn, 1);
    chk("slow_addr_stable", stable, 1);
    // reset in the middle of an access
    mem_ready = 1'b0; do_reset();
    req = 4'b0010;
    step();
    chk("rst_mid_grant", {grant, mem_req}, {4'b0010, 1'b1});
    reset = 1'b0;
    step();
    chk("rst_mid_abandon", {grant, mem_req, done, err, busy}, 14'h0);
    reset = 1'b1;
    step();
    chk("rst_mid_regrant", {grant, mem_req}, {4'b0010, 1'b1});
    mem_ready = 1'b1; req = '0;
    step(); step();
    // pointer restarts at NREQ-1 after reset: requester 0 wins over 1
    mem_ready = 1'b0; do_reset();
    req = 4'b0011;
    step();
    chk("rst_last_ptr", grant, 4'b0001);
`ifdef ABUS_TIMEOUT_EN
    do_reset();
    req = 4'b0001; mem_ready = 1'b0;
    step();
    req = '0; acc = 0; nerr = 0; ndn = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) acc++;
      if (err == 4'b0001) nerr++;
      else if (err != 0) nerr += 100;
      if (done != 0) ndn++;
      if (!busy) break;
      step();
    end
    chk("to_access_cycles", acc, TO);
    chk("to_err_pulses", nerr, 1);
    chk("to_no_done", ndn, 0);
    req = 4'b0001;
    step();
    req = '0; acc = 0; nerr = 0; ndn = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req) acc++;
      if (err != 0) nerr++;
      if (done == 4'b0001) ndn++;
      if (!busy) break;
      mem_ready = (acc == TO);
      step();
    end
    mem_ready = 1'b0;
    chk("to_ready_wins_cycles", acc, TO);
    chk("to_ready_wins_done", ndn, 1);
    chk("to_ready_wins_no_err", nerr, 0);
`endif
    // randomized traffic against the reference model
    req = '0; mem_ready = 1'b0; reset = 1'b0;
    madv(); step();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 59) != 0);
      req = 4'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      if (m_win < 0) begin
        we = 4'($urandom);
        addr_in = {$urandom, $urandom};
      end
      madv();
      step();
      chk("rand", {grant, abus_out, mem_req, mem_we, done, err, busy}, mexp());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
